// File: rtl/crc_pkg.sv
// rtl/crc_pkg.sv - shared CRC constants, FSM state type and bit-reflection helper
// Ships the CRC-32 (Ethernet FCS) and CRC-16/CCITT-FALSE parameter sets.
package crc_pkg;

  localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_XOR_OUT = 32'hFFFFFFFF;
  localparam bit          CRC32_REFIN   = 1'b1;
  localparam bit          CRC32_REFOUT  = 1'b1;
  localparam logic [31:0] CRC32_RESIDUE = 32'h2144DF1C;

  localparam logic [31:0] CRC16_POLY    = 32'h00001021;
  localparam logic [31:0] CRC16_INIT    = 32'h0000FFFF;
  localparam logic [31:0] CRC16_XOR_OUT = 32'h00000000;
  localparam bit          CRC16_REFIN   = 1'b0;
  localparam bit          CRC16_REFOUT  = 1'b0;
  localparam logic [31:0] CRC16_RESIDUE = 32'h00000000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_RESULT = 2'd2
  } state_e;

  // Mirrors the low n bits of v; bits at n and above come back as zero.
  function automatic logic [31:0] reflect_n(input logic [31:0] v, input int n);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < n) r[5'(i)] = v[5'(n - 1 - i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/crc_byte_step.sv
// rtl/crc_byte_step.sv - folds one byte into a CRC register (combinational)
// Bits enter an MSB-first shift register; REFIN chooses which end of the byte goes first.
module crc_byte_step #(
  parameter int          CRC_W = 32,
  parameter logic [31:0] POLY  = 32'h04C11DB7,
  parameter bit          REFIN = 1'b1
) (
  input  logic [CRC_W-1:0] crc_i,
  input  logic [7:0]       byte_i,
  input  logic             en_i,
  output logic [CRC_W-1:0] crc_o
);

  logic [CRC_W-1:0] c;
  logic             bit_in;
  logic             fb;

  always_comb begin
    c      = crc_i;
    bit_in = 1'b0;
    fb     = 1'b0;
    for (int b = 0; b < 8; b++) begin
      bit_in = REFIN ? byte_i[3'(b)] : byte_i[3'(7 - b)];
      fb     = c[CRC_W-1] ^ bit_in;
      c      = {c[CRC_W-2:0], 1'b0} ^ (fb ? POLY[CRC_W-1:0] : '0);
    end
    crc_o = en_i ? c : crc_i;
  end

endmodule

// File: rtl/crc_stream_engine.sv
// rtl/crc_stream_engine.sv - streaming CRC generator/checker with held result channel
// One crc_byte_step per byte lane is chained so a whole beat is absorbed every clock.
module crc_stream_engine
  import crc_pkg::*;
#(
  parameter int          CRC_W   = 32,
  parameter logic [31:0] POLY    = CRC32_POLY,
  parameter logic [31:0] INIT    = CRC32_INIT,
  parameter logic [31:0] XOR_OUT = CRC32_XOR_OUT,
  parameter bit          REFIN   = CRC32_REFIN,
  parameter bit          REFOUT  = CRC32_REFOUT,
  parameter int          DATA_W  = 32,
  parameter logic [31:0] RESIDUE = CRC32_RESIDUE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  input  logic [DATA_W-1:0]     s_data_i,
  input  logic [DATA_W/8-1:0]   s_keep_i,
  input  logic                  s_last_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [CRC_W-1:0]      m_crc_o,
  output logic                  m_ok_o,
  output logic [15:0]           m_bytes_o
);

  localparam int LANES = DATA_W / 8;

  state_e           state_q, state_d;
  logic [CRC_W-1:0] crc_q, crc_d;
  logic [CRC_W-1:0] res_crc_q, res_crc_d;
  logic             res_ok_q, res_ok_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [15:0]      res_bytes_q, res_bytes_d;
  logic [16:0]      cnt_sum;
  logic [15:0]      cnt_acc;
  logic             accept;
  logic [CRC_W-1:0] chain [LANES+1];
  logic [31:0]      crc_ext;
  logic [31:0]      crc_refl;
  logic [CRC_W-1:0] crc_final;
  logic             refl_parity;

  assign chain[0] = crc_q;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    crc_byte_step #(
      .CRC_W (CRC_W),
      .POLY  (POLY),
      .REFIN (REFIN)
    ) u_step (
      .crc_i  (chain[g]),
      .byte_i (s_data_i[8*g +: 8]),
      .en_i   (s_keep_i[g]),
      .crc_o  (chain[g+1])
    );
  end

  assign s_ready_o = (state_q != ST_RESULT) | m_ready_i;
  assign accept    = s_valid_i & s_ready_o;
  assign m_valid_o = (state_q == ST_RESULT);
  assign m_crc_o   = res_crc_q;
  assign m_ok_o    = res_ok_q;
  assign m_bytes_o = res_bytes_q;

  // Widest register is 32 bits; narrower CRCs are reflected in the low bits only.
  always_comb begin
    crc_ext                = '0;
    crc_ext[CRC_W-1:0]     = chain[LANES];
    crc_refl               = REFOUT ? reflect_n(crc_ext, CRC_W) : crc_ext;
    crc_final              = crc_refl[CRC_W-1:0] ^ XOR_OUT[CRC_W-1:0];
    refl_parity            = ^crc_refl;
  end

  always_comb begin
    cnt_sum = {1'b0, cnt_q} + 17'($countones(s_keep_i));
    cnt_acc = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
  end

  always_comb begin
    state_d     = state_q;
    crc_d       = crc_q;
    cnt_d       = cnt_q;
    res_crc_d   = res_crc_q;
    res_ok_d    = res_ok_q;
    res_bytes_d = res_bytes_q;
    if (clr_i) begin
      state_d = ST_IDLE;
      crc_d   = INIT[CRC_W-1:0];
      cnt_d   = '0;
    end else if (accept) begin
      if (s_last_i) begin
        // Register reloads INIT here so a following frame can start on the next beat.
        state_d     = ST_RESULT;
        crc_d       = INIT[CRC_W-1:0];
        cnt_d       = '0;
        res_crc_d   = crc_final;
        res_ok_d    = (crc_final == RESIDUE[CRC_W-1:0]);
        res_bytes_d = cnt_acc;
      end else begin
        state_d = ST_RUN;
        crc_d   = chain[LANES];
        cnt_d   = cnt_acc;
      end
    end else if (state_q == ST_RESULT && m_ready_i) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      crc_q       <= INIT[CRC_W-1:0];
      cnt_q       <= '0;
      res_crc_q   <= '0;
      res_ok_q    <= 1'b0;
      res_bytes_q <= '0;
    end else begin
      state_q     <= state_d;
      crc_q       <= crc_d;
      cnt_q       <= cnt_d;
      res_crc_q   <= res_crc_d;
      res_ok_q    <= res_ok_d;
      res_bytes_q <= res_bytes_d;
    end
  end

  logic unused_refl;
  assign unused_refl = refl_parity;

endmodule

// File: tb/tb_crc_stream_engine.sv
// tb/tb_crc_stream_engine.sv - bench for crc_stream_engine (CRC-32 x32 and CRC-16 x8 instances)
module tb_crc_stream_engine;
  import crc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  logic        clr, s_valid, s_ready, s_last, m_valid, m_ready, m_ok;
  logic [31:0] s_data, m_crc;
  logic [3:0]  s_keep;
  logic [15:0] m_bytes;

  logic        b_clr, b_s_valid, b_s_ready, b_s_last, b_m_valid, b_m_ready, b_m_ok;
  logic [7:0]  b_s_data;
  logic [0:0]  b_s_keep;
  logic [15:0] b_m_crc, b_m_bytes;

  crc_stream_engine u_dut (
    .clk(clk), .rst_n(rst_n), .clr_i(clr), .s_valid_i(s_valid), .s_ready_o(s_ready),
    .s_data_i(s_data), .s_keep_i(s_keep), .s_last_i(s_last), .m_valid_o(m_valid),
    .m_ready_i(m_ready), .m_crc_o(m_crc), .m_ok_o(m_ok), .m_bytes_o(m_bytes)
  );

  crc_stream_engine #(
    .CRC_W(16), .POLY(CRC16_POLY), .INIT(CRC16_INIT), .XOR_OUT(CRC16_XOR_OUT),
    .REFIN(CRC16_REFIN), .REFOUT(CRC16_REFOUT), .DATA_W(8), .RESIDUE(CRC16_RESIDUE)
  ) u_dut16 (
    .clk(clk), .rst_n(rst_n), .clr_i(b_clr), .s_valid_i(b_s_valid), .s_ready_o(b_s_ready),
    .s_data_i(b_s_data), .s_keep_i(b_s_keep), .s_last_i(b_s_last), .m_valid_o(b_m_valid),
    .m_ready_i(b_m_ready), .m_crc_o(b_m_crc), .m_ok_o(b_m_ok), .m_bytes_o(b_m_bytes)
  );

  typedef struct {
    int              nb;
    logic [3:0][31:0] d;
    logic [3:0][3:0]  k;
    bit              known;
    logic [31:0]     crc;
    logic            ok;
    logic [15:0]     bytes;
  } vec_t;

  typedef struct {
    logic [31:0] crc;
    logic        ok;
    logic [15:0] bytes;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] last_crc = 32'h0;
  vec_t        vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference CRC-32: reflected byte-wise form (poly 0xEDB88320), independent of the shift chain.
  function automatic logic [31:0] crc32_model(input logic [7:0] bq[$]);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (bq[i]) begin
      c = c ^ {24'h0, bq[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got crc %h with empty scoreboard", m_crc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_crc", m_crc, e.crc);
        check("sb_ok", {31'h0, m_ok}, {31'h0, e.ok});
        check("sb_bytes", {16'h0, m_bytes}, {16'h0, e.bytes});
        last_crc = e.crc;
      end
    end
  end

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    int n;
    s_valid = 1'b1; s_data = d; s_keep = k; s_last = l;
    n = 0;
    do begin @(negedge clk); n++; end while (!s_ready && n < 200);
    if (!s_ready) check("beat_accept_timeout", {31'h0, s_ready}, 32'h1);
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input vec_t v);
    logic [7:0] bq[$];
    exp_t e;
    for (int i = 0; i < v.nb; i++)
      for (int l = 0; l < 4; l++)
        if (v.k[i][l]) bq.push_back(v.d[i][8*l +: 8]);
    e.crc   = v.known ? v.crc : crc32_model(bq);
    e.ok    = v.known ? v.ok : (e.crc == 32'h2144DF1C);
    e.bytes = v.known ? v.bytes : 16'(bq.size());
    sb.push_back(e);
    for (int i = 0; i < v.nb; i++) send_beat(v.d[i], v.k[i], (i == v.nb - 1));
  endtask

  task automatic drain();
    int n;
    s_valid = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 100) begin @(posedge clk); #1; n++; end
    check("drain", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t rv;
    logic [7:0] q5678[$];
    exp_t e2;

    vecs[0] = '{nb:3, d:{32'h0, 32'h00000039, 32'h38373635, 32'h34333231},
                k:{4'h0, 4'h1, 4'hF, 4'hF}, known:1, crc:32'hCBF43926, ok:1'b0, bytes:16'd9};
    vecs[1] = '{nb:4, d:{32'h000000CB, 32'hF4392639, 32'h38373635, 32'h34333231},
                k:{4'h1, 4'hF, 4'hF, 4'hF}, known:1, crc:32'h2144DF1C, ok:1'b1, bytes:16'd13};
    vecs[2] = '{nb:4, d:{32'h000000CB, 32'hF4392639, 32'h38373635, 32'h34333230},
                k:{4'h1, 4'hF, 4'hF, 4'hF}, known:0, crc:32'h0, ok:1'b0, bytes:16'd0};
    vecs[3] = '{nb:2, d:{32'h0, 32'h0, 32'hA5A5A5A5, 32'h34333231},
                k:{4'h0, 4'h0, 4'h0, 4'hF}, known:1, crc:32'h9BE3E0A3, ok:1'b0, bytes:16'd4};
    vecs[4] = '{nb:1, d:{32'h0, 32'h0, 32'h0, 32'h12345678},
                k:{4'h0, 4'h0, 4'h0, 4'h0}, known:1, crc:32'h00000000, ok:1'b0, bytes:16'd0};
    vecs[5] = '{nb:2, d:{32'h0, 32'h0, 32'hC0FFEE11, 32'hDEADBEEF},
                k:{4'h0, 4'h0, 4'h6, 4'hF}, known:0, crc:32'h0, ok:1'b0, bytes:16'd0};

    rst_n = 1'b0; clr = 1'b0; s_valid = 1'b0; s_data = '0; s_keep = '0; s_last = 1'b0;
    m_ready = 1'b1;
    b_clr = 1'b0; b_s_valid = 1'b0; b_s_data = '0; b_s_keep = 1'b1; b_s_last = 1'b0;
    b_m_ready = 1'b1;
    #3;
    check("rst_m_valid", {31'h0, m_valid}, 32'h0);
    check("rst_s_ready", {31'h0, s_ready}, 32'h1);
    check("rst_m_crc", m_crc, 32'h0);
    check("rst_m_ok", {31'h0, m_ok}, 32'h0);
    check("rst_m_bytes", {16'h0, m_bytes}, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Table vectors sent back to back with m_ready held high.
    for (int v = 0; v < 6; v++) send_frame(vecs[v]);
    for (int f = 0; f < 6; f++) begin
      rv.nb = $urandom_range(1, 4);
      rv.known = 1'b0; rv.crc = '0; rv.ok = 1'b0; rv.bytes = '0;
      for (int i = 0; i < 4; i++) begin
        rv.d[i] = $urandom;
        rv.k[i] = (i == rv.nb - 1) ? 4'($urandom_range(0, 15)) : 4'hF;
      end
      send_frame(rv);
    end
    drain();

    // Backpressure: result held while a second frame's last beat is stalled.
    m_ready = 1'b0;
    sb.push_back('{crc:32'h9BE3E0A3, ok:1'b0, bytes:16'd4});
    send_beat(32'h34333231, 4'hF, 1'b1);
    q5678 = '{8'h35, 8'h36, 8'h37, 8'h38};
    e2 = '{crc:crc32_model(q5678), ok:1'b0, bytes:16'd4};
    sb.push_back(e2);
    s_valid = 1'b1; s_data = 32'h38373635; s_keep = 4'hF; s_last = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_m_valid", {31'h0, m_valid}, 32'h1);
      check("bp_m_crc", m_crc, 32'h9BE3E0A3);
      check("bp_m_bytes", {16'h0, m_bytes}, 32'd4);
      check("bp_s_ready", {31'h0, s_ready}, 32'h0);
    end
    @(posedge clk); #1;
    m_ready = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0;
    check("bp_no_gap_valid", {31'h0, m_valid}, 32'h1);
    check("bp_second_crc", m_crc, e2.crc);
    drain();

    // clr mid-frame: the beat presented with clr is a last beat and must be dropped.
    send_beat(32'h34333231, 4'hF, 1'b0);
    s_valid = 1'b1; s_data = 32'hDEADBEEF; s_keep = 4'hF; s_last = 1'b1; clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0; s_valid = 1'b0;
    @(negedge clk);
    check("clr_m_valid", {31'h0, m_valid}, 32'h0);
    check("clr_m_crc_held", m_crc, last_crc);
    @(posedge clk); #1;
    send_frame(vecs[0]);
    drain();

    // Asynchronous reset while a frame is open.
    send_beat(32'h34333231, 4'hF, 1'b0);
    s_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_m_valid", {31'h0, m_valid}, 32'h0);
    check("arst_m_crc", m_crc, 32'h0);
    check("arst_m_ok", {31'h0, m_ok}, 32'h0);
    check("arst_m_bytes", {16'h0, m_bytes}, 32'h0);
    check("arst_s_ready", {31'h0, s_ready}, 32'h1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_frame(vecs[0]);
    drain();

    // CRC-16/CCITT-FALSE on the 8-bit instance.
    for (int i = 0; i < 9; i++) begin
      int n;
      b_s_valid = 1'b1; b_s_data = 8'(8'h31 + i); b_s_last = (i == 8);
      n = 0;
      do begin @(negedge clk); n++; end while (!b_s_ready && n < 50);
      if (!b_s_ready) check("crc16_accept_timeout", {31'h0, b_s_ready}, 32'h1);
      @(posedge clk); #1;
    end
    b_s_valid = 1'b0;
    check("crc16_m_valid", {31'h0, b_m_valid}, 32'h1);
    check("crc16_m_crc", {16'h0, b_m_crc}, 32'h000029B1);
    check("crc16_m_bytes", {16'h0, b_m_bytes}, 32'd9);
    check("crc16_m_ok", {31'h0, b_m_ok}, 32'h0);
    @(posedge clk); #1;
    check("crc16_released", {31'h0, b_m_valid}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
